// File: rtl/mem_stage_ctrl.sv
// EX/MEM stage register plus req/ack data-memory port: store lane building, load alignment/extension,
// misalign and timeout traps, registered write-back bundle. Upstream freezes while mem_stall is high.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int SIDE_W  = 36,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic              d_MemWr,
  input  logic              d_MemtoReg,
  input  logic              d_RegWr,
  input  logic              d_loadext,
  input  logic [1:0]        d_Dsize,
  input  logic [31:0]       d_ExecResult,
  input  logic [31:0]       d_BusB,
  input  logic [4:0]        d_Rw,
  input  logic [SIDE_W-1:0] d_side,
  input  logic              flush,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_RegWr,
  output logic [4:0]        wb_Rw,
  output logic [31:0]       wb_data,
  output logic [SIDE_W-1:0] wb_side,
  output logic              wb_misalign,
  output logic              wb_buserr
);
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t            state, state_nxt;
  logic [7:0]        wait_cnt;
  logic              s_valid, s_memwr, s_memtoreg, s_regwr, s_loadext;
  logic [1:0]        s_dsize;
  logic [31:0]       s_res, s_busb;
  logic [4:0]        s_rw;
  logic [SIDE_W-1:0] s_side;

  logic        d_mem_ok, s_misalign, s_load, in_req, timeout, buserr, retire;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data, wb_data_nxt;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b11:   return |a;
      default: return 1'b1;
    endcase
  endfunction

  // REQ is entered on the capture edge itself so a zero-wait ack lands in the first cycle.
  assign d_mem_ok   = d_valid & ~flush & (d_MemWr | d_MemtoReg) & ~is_misaligned(d_Dsize, d_ExecResult[1:0]);
  assign s_misalign = s_valid & (s_memwr | s_memtoreg) & is_misaligned(s_dsize, s_res[1:0]);
  assign s_load     = s_memtoreg & ~s_memwr;
  assign in_req     = (state == REQ);
  assign timeout    = in_req & (wait_cnt == TO_CNT);
  assign mem_stall  = in_req & ~dmem_ack & ~timeout;
  assign buserr     = timeout & ~dmem_ack;
  assign retire     = s_valid & ~mem_stall;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_mem_ok) state_nxt = REQ;
      REQ:     if (dmem_ack || timeout) state_nxt = d_mem_ok ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= mem_stall ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid    <= 1'b0;
      s_memwr    <= 1'b0;
      s_memtoreg <= 1'b0;
      s_regwr    <= 1'b0;
      s_loadext  <= 1'b0;
      s_dsize    <= 2'b00;
      s_res      <= 32'd0;
      s_busb     <= 32'd0;
      s_rw       <= 5'd0;
      s_side     <= '0;
    end else if (!mem_stall) begin
      s_valid    <= d_valid & ~flush;
      s_memwr    <= d_MemWr;
      s_memtoreg <= d_MemtoReg;
      s_regwr    <= d_RegWr;
      s_loadext  <= d_loadext;
      s_dsize    <= d_Dsize;
      s_res      <= d_ExecResult;
      s_busb     <= d_BusB;
      s_rw       <= d_Rw;
      s_side     <= d_side;
    end
  end

  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = 4'b0000;
    dmem_wdata = 32'd0;
    if (in_req) begin
      dmem_req  = 1'b1;
      dmem_we   = s_memwr;
      dmem_addr = {s_res[ADDR_W-1:2], 2'b00};
      case (s_dsize)
        2'b00: begin
          dmem_be    = 4'b0001 << s_res[1:0];
          dmem_wdata = {4{s_busb[7:0]}};
        end
        2'b01: begin
          dmem_be    = s_res[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{s_busb[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = s_busb;
        end
      endcase
      if (!s_memwr) dmem_wdata = 32'd0;
    end
  end

  always_comb begin
    ld_byte   = dmem_rdata[8*s_res[1:0] +: 8];
    ld_half   = s_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (s_dsize)
      2'b00:   load_data = {{24{s_loadext & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{s_loadext & ld_half[15]}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
    wb_data_nxt = s_load ? load_data : s_res;
    if (s_misalign || buserr) wb_data_nxt = 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_RegWr    <= 1'b0;
      wb_Rw       <= 5'd0;
      wb_data     <= 32'd0;
      wb_side     <= '0;
      wb_misalign <= 1'b0;
      wb_buserr   <= 1'b0;
    end else begin
      wb_valid <= retire;
      if (retire) begin
        wb_RegWr    <= s_regwr & ~s_misalign & ~buserr;
        wb_Rw       <= s_rw;
        wb_data     <= wb_data_nxt;
        wb_side     <= s_side;
        wb_misalign <= s_misalign;
        wb_buserr   <= buserr;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-cycle expectations derived from access rules, checked on negedge.
module tb_mem_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        d_valid = 0, d_MemWr = 0, d_MemtoReg = 0, d_RegWr = 0, d_loadext = 0, flush = 0;
  logic [1:0]  d_Dsize = 2'b00;
  logic [31:0] d_ExecResult = 0, d_BusB = 0, dmem_rdata = 0;
  logic [4:0]  d_Rw = 0;
  logic [35:0] d_side = 0;
  logic        dmem_ack = 0;
  logic        mem_stall, dmem_req, dmem_we, wb_valid, wb_RegWr, wb_misalign, wb_buserr;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_Rw;
  logic [35:0] wb_side;

  mem_stage_ctrl #(.ADDR_W(32), .SIDE_W(36), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_MemWr(d_MemWr), .d_MemtoReg(d_MemtoReg),
    .d_RegWr(d_RegWr), .d_loadext(d_loadext), .d_Dsize(d_Dsize), .d_ExecResult(d_ExecResult),
    .d_BusB(d_BusB), .d_Rw(d_Rw), .d_side(d_side), .flush(flush), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_RegWr(wb_RegWr), .wb_Rw(wb_Rw), .wb_data(wb_data), .wb_side(wb_side),
    .wb_misalign(wb_misalign), .wb_buserr(wb_buserr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, regwr, ext;
    logic [1:0]  size;
    logic [31:0] res, b;
    logic [4:0]  rw;
    logic [35:0] side;
  } op_t;

  int n_checks = 0, n_fail = 0;

  // Expected DUT outputs for the current cycle, written by the driver, compared at negedge.
  logic        chk_en = 1'b0, e_zero = 1'b1;
  logic        e_stall = 0, e_req = 0, e_we = 0, e_wbv = 0, e_regwr = 0, e_mis = 0, e_berr = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_data = 0;
  logic [3:0]  e_be = 0;
  logic [4:0]  e_rw = 0;
  logic [35:0] e_side = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic f_mis(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b10) || (size == 2'b01 && a % 2 != 0) || (size == 2'b11 && a != 0);
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] a);
    int nbytes;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    return 4'(((1 << nbytes) - 1) << a);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] b);
    if (size == 2'b00) return (b & 32'hFF) * 32'h01010101;
    if (size == 2'b01) return (b & 32'hFFFF) * 32'h00010001;
    return b;
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] size, input logic ext,
                                         input logic [1:0] a, input logic [31:0] rdata);
    logic [31:0] sh, mask;
    int bits;
    if (size == 2'b11) return rdata;
    bits = (size == 2'b00) ? 8 : 16;
    sh   = rdata >> (8 * a);
    mask = (32'd1 << bits) - 32'd1;
    sh   = sh & mask;
    if (ext && sh >= (32'd1 << (bits - 1))) sh = sh | ~mask;
    return sh;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_stall", mem_stall, e_stall);
      check("dmem_req", dmem_req, e_req);
      check("wb_valid", wb_valid, e_wbv);
      if (e_req) begin
        check("dmem_we", dmem_we, e_we);
        check("dmem_addr", dmem_addr, e_addr);
        check("dmem_be", dmem_be, e_be);
        check("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (e_wbv) begin
        check("wb_RegWr", wb_RegWr, e_regwr);
        check("wb_Rw", wb_Rw, e_rw);
        check("wb_data", wb_data, e_data);
        check("wb_side", wb_side, e_side);
        check("wb_misalign", wb_misalign, e_mis);
        check("wb_buserr", wb_buserr, e_berr);
      end
      if (e_zero)
        check("outputs_zero", |{mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid,
                                wb_RegWr, wb_Rw, wb_data, wb_side, wb_misalign, wb_buserr}, 0);
    end
  end

  task automatic drive_op(input op_t o);
    d_MemWr = o.wr; d_MemtoReg = o.rd; d_RegWr = o.regwr; d_loadext = o.ext;
    d_Dsize = o.size; d_ExecResult = o.res; d_BusB = o.b; d_Rw = o.rw; d_side = o.side;
  endtask

  task automatic set_req_exp(input op_t o);
    e_req   = 1'b1;
    e_we    = o.wr;
    e_addr  = {o.res[31:2], 2'b00};
    e_be    = f_be(o.size, o.res[1:0]);
    e_wdata = o.wr ? f_wdata(o.size, o.b) : 32'd0;
  endtask

  // k = cycle after capture in which ack arrives (negative: never). late = ack pulse after retirement.
  task automatic run_op(input op_t o, input int k, input logic [31:0] rdata, input logic flsh, input logic late);
    logic memop, mis, berr;
    @(posedge clk); #1;
    dmem_ack = 0;
    drive_op(o); d_valid = 1'b1; flush = flsh;
    e_stall = 0; e_req = 0; e_wbv = 0;
    @(posedge clk); #1;
    d_valid = 1'b0; flush = 1'b0;
    memop = (o.wr || o.rd) && !flsh;
    mis   = memop && f_mis(o.size, o.res[1:0]);
    berr  = 1'b0;
    if (memop && !mis) begin
      for (int c = 0; c <= TO; c++) begin
        set_req_exp(o);
        dmem_ack   = (c == k);
        dmem_rdata = (c == k) ? rdata : 32'hDEADBEEF;
        e_stall    = (c != k) && (c != TO);
        if (!e_stall) begin
          berr = (c != k);
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      dmem_ack = 0;
    end else begin
      @(posedge clk); #1;
    end
    e_req = 0; e_stall = 0; e_wbv = !flsh;
    e_mis = mis; e_berr = berr; e_rw = o.rw; e_side = o.side;
    e_regwr = o.regwr && !mis && !berr;
    e_data  = (mis || berr) ? 32'd0 : (o.rd && !o.wr) ? f_load(o.size, o.ext, o.res[1:0], rdata) : o.res;
    if (late) begin
      dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    end
  endtask

  function automatic op_t mk(input logic wr, rd, regwr, ext, input logic [1:0] size,
                             input logic [31:0] res, b, input logic [4:0] rw, input logic [35:0] side);
    op_t o;
    o.wr = wr; o.rd = rd; o.regwr = regwr; o.ext = ext; o.size = size;
    o.res = res; o.b = b; o.rw = rw; o.side = side;
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    // Literal anchors for the model functions.
    check("pin_lh_signed", f_load(2'b01, 1'b1, 2'b10, 32'h80010000), 32'hFFFF8001);
    check("pin_lh_zero", f_load(2'b01, 1'b0, 2'b10, 32'h80010000), 32'h00008001);
    check("pin_lb_signed", f_load(2'b00, 1'b1, 2'b01, 32'h00008000), 32'hFFFFFF80);
    check("pin_be_byte3", f_be(2'b00, 2'b11), 4'b1000);
    check("pin_be_half_hi", f_be(2'b01, 2'b10), 4'b1100);
    check("pin_wdata_byte", f_wdata(2'b00, 32'h123456AB), 32'hABABABAB);
    check("pin_mis_word", f_mis(2'b11, 2'b01), 1'b1);

    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    e_zero = 1'b0;

    run_op(mk(0, 0, 1, 0, 2'b11, 32'h1234, 32'h0, 5'd7, 36'h9ABCD0123), 0, 0, 0, 0);
    run_op(mk(1, 0, 0, 0, 2'b00, 32'h103, 32'h123456AB, 5'd0, 36'h1), 3, 0, 0, 0);
    run_op(mk(0, 1, 1, 1, 2'b01, 32'h202, 32'h0, 5'd3, 36'h2), 2, 32'h80010000, 0, 0);
    run_op(mk(0, 1, 1, 0, 2'b01, 32'h202, 32'h0, 5'd4, 36'h3), 0, 32'h80010000, 0, 0);
    run_op(mk(0, 1, 1, 1, 2'b11, 32'h301, 32'h0, 5'd5, 36'h4), 0, 0, 0, 0);
    run_op(mk(1, 0, 0, 0, 2'b10, 32'h100, 32'h55, 5'd0, 36'h5), 0, 0, 0, 0);
    run_op(mk(0, 1, 1, 1, 2'b00, 32'h101, 32'h0, 5'd6, 36'h6), 0, 32'h00008000, 0, 0);
    run_op(mk(1, 1, 0, 0, 2'b11, 32'h200, 32'hCAFEF00D, 5'd8, 36'h7), 1, 32'h0, 0, 0);
    run_op(mk(1, 0, 0, 0, 2'b01, 32'h102, 32'h0000BEEF, 5'd0, 36'h8), 0, 0, 0, 0);
    run_op(mk(0, 1, 1, 0, 2'b11, 32'h400, 32'h0, 5'd9, 36'hF00000001), -1, 0, 0, 1);
    run_op(mk(0, 0, 1, 0, 2'b11, 32'h5555, 32'h0, 5'd10, 36'hA), 0, 0, 0, 0);
    run_op(mk(0, 1, 1, 0, 2'b11, 32'h404, 32'h0, 5'd11, 36'hB), TO, 32'h87654321, 0, 0);
    run_op(mk(0, 0, 1, 0, 2'b11, 32'h777, 32'h0, 5'd12, 36'hC), 0, 0, 1, 0);

    // Reset while a load is waiting for its ack.
    o = mk(0, 1, 1, 0, 2'b11, 32'h600, 32'h0, 5'd13, 36'hD);
    @(posedge clk); #1;
    dmem_ack = 0; drive_op(o); d_valid = 1'b1;
    e_stall = 0; e_req = 0; e_wbv = 0;
    @(posedge clk); #1;
    d_valid = 1'b0;
    set_req_exp(o); e_stall = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    e_req = 0; e_stall = 0; e_wbv = 0; e_zero = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    e_zero = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
